// File: rtl/rfid_pkg.sv
// Shared definitions for the ISO 14443-A PICC transmit path: framer states,
// CRC_A constants and the default ETU length at fc/4.
package rfid_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SOF,
        DATA,
        PARITY,
        CRC_LO,
        CRC_HI,
        EOF,
        ABORT,
        GUARD
    } tx_state_t;

    localparam logic [15:0] CRC_A_INIT       = 16'h6363;
    localparam logic [15:0] CRC_A_POLY       = 16'h8408;
    localparam int          ETU_CLKS_DEFAULT = 32;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/crc_a_byte.sv
// Combinational CRC_A update over one byte (reflected polynomial 0x8408,
// data consumed LSB first).
module crc_a_byte
    import rfid_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_A_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/picc_tx_framer.sv
// ISO 14443-A 106 kbit/s PICC transmit framer: SOF, bytes LSB-first with odd
// parity, optional CRC_A trailer when PICC_TX_CRC_A_EN is defined.
module picc_tx_framer
    import rfid_pkg::*;
#(
    parameter int ETU_CLKS = ETU_CLKS_DEFAULT,
    parameter int CNT_W    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       tx_enable,
    output logic       tx_data,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    tx_state_t        state, state_nxt;
    logic [CNT_W-1:0] etu_cnt;
    logic             etu_end;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [7:0]       hold_data;
    logic             hold_last;
    logic             hold_full;
    logic             last_sent;
    logic             rdy_en;
    logic             accept;
    logic             byte_avail;
    logic             load_byte;
    logic [7:0]       byte_in;
    logic             last_in;
    logic             shifting;

`ifdef PICC_TX_CRC_A_EN
    logic [15:0] crc_q;
    logic [15:0] crc_nxt;
    logic        load_crc_lo;
    logic        load_crc_hi;

    crc_a_byte u_crc (
        .crc_in  (crc_q),
        .data    (byte_in),
        .crc_out (crc_nxt)
    );
`endif

    assign etu_end = (etu_cnt == CNT_W'(ETU_CLKS - 1));

    // Once the final byte is latched nothing more is taken until the guard ends.
    assign s_ready = rdy_en && !hold_full && !(hold_full && hold_last) && !last_sent
                     && (state != GUARD) && (state != ABORT);
    assign accept     = s_valid && s_ready;
    assign byte_avail = hold_full || accept;
    assign byte_in    = hold_full ? hold_data : s_data;
    assign last_in    = hold_full ? hold_last : s_last;
    assign shifting   = (state == DATA) || (state == CRC_LO) || (state == CRC_HI);

    assign tx_enable = (state == SOF) || (state == DATA) || (state == PARITY)
                       || (state == CRC_LO) || (state == CRC_HI);
    assign busy      = (state != IDLE);
    assign done      = (state == EOF);
    assign underrun  = (state == ABORT);

    always_comb begin
        tx_data = 1'b0;
        case (state)
            SOF:            tx_data = 1'b1;
            DATA:           tx_data = shift_q[0];
            PARITY:         tx_data = par_q;
            CRC_LO, CRC_HI: tx_data = (bit_cnt == 4'd8) ? par_q : shift_q[0];
            default:        tx_data = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load_byte = 1'b0;
`ifdef PICC_TX_CRC_A_EN
        load_crc_lo = 1'b0;
        load_crc_hi = 1'b0;
`endif
        case (state)
            IDLE: if (accept) state_nxt = SOF;
            SOF: begin
                if (etu_end) begin
                    state_nxt = DATA;
                    load_byte = 1'b1;
                end
            end
            DATA: if (etu_end && bit_cnt == 4'd7) state_nxt = PARITY;
            PARITY: begin
                // A byte accepted in this very cycle counts as held.
                if (etu_end) begin
                    if (byte_avail) begin
                        state_nxt = DATA;
                        load_byte = 1'b1;
                    end else if (last_sent) begin
`ifdef PICC_TX_CRC_A_EN
                        state_nxt   = CRC_LO;
                        load_crc_lo = 1'b1;
`else
                        state_nxt = EOF;
`endif
                    end else begin
                        state_nxt = ABORT;
                    end
                end
            end
`ifdef PICC_TX_CRC_A_EN
            CRC_LO: begin
                if (etu_end && bit_cnt == 4'd8) begin
                    state_nxt   = CRC_HI;
                    load_crc_hi = 1'b1;
                end
            end
            CRC_HI: if (etu_end && bit_cnt == 4'd8) state_nxt = EOF;
`endif
            EOF:     state_nxt = GUARD;
            ABORT:   state_nxt = GUARD;
            GUARD:   if (etu_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            etu_cnt <= '0;
            bit_cnt <= '0;
        end else if (state_nxt != state) begin
            etu_cnt <= '0;
            bit_cnt <= '0;
        end else if (etu_end) begin
            etu_cnt <= '0;
            if (shifting) bit_cnt <= bit_cnt + 4'd1;
        end else begin
            etu_cnt <= etu_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            par_q   <= 1'b0;
        end else if (load_byte) begin
            shift_q <= byte_in;
            par_q   <= odd_parity(byte_in);
`ifdef PICC_TX_CRC_A_EN
        end else if (load_crc_lo) begin
            shift_q <= crc_q[7:0];
            par_q   <= odd_parity(crc_q[7:0]);
        end else if (load_crc_hi) begin
            shift_q <= crc_q[15:8];
            par_q   <= odd_parity(crc_q[15:8]);
`endif
        end else if (etu_end && shifting) begin
            shift_q <= {1'b0, shift_q[7:1]};
        end
    end

    // A direct load from s_data (accept at parity end) leaves the holding register empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_last <= 1'b0;
        end else if (state == ABORT || load_byte) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= s_data;
            hold_last <= s_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sent <= 1'b0;
            rdy_en    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (state == GUARD)            last_sent <= 1'b0;
            else if (load_byte && last_in) last_sent <= 1'b1;
        end
    end

`ifdef PICC_TX_CRC_A_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             crc_q <= CRC_A_INIT;
        else if (state == IDLE) crc_q <= CRC_A_INIT;
        else if (load_byte)     crc_q <= crc_nxt;
    end
`endif

endmodule

// File: tb/tb_picc_tx_framer.sv
// Scoreboard bench for picc_tx_framer: frame-level reference model feeds
// expected bit/length/pulse queues that a negedge monitor consumes.
module tb_picc_tx_framer;

    localparam int ETU = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       s_ready, tx_enable, tx_data, busy, done, underrun;

    picc_tx_framer #(.ETU_CLKS(ETU), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .tx_enable (tx_enable),
        .tx_data   (tx_data),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    bit         exp_bits[$];
    int         exp_len[$];
    bit         exp_und[$];
    logic [7:0] fb[$];
    time        acc_t[$];
    time        first_acc_time = 0;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b);
        logic [7:0] ch;
        ch = b ^ crc[7:0];
        ch = ch ^ (ch << 4);
        return (crc >> 8) ^ ({8'h00, ch} << 8) ^ ({8'h00, ch} << 3) ^ ({8'h00, ch} >> 4);
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) begin
            exp_bits.push_back(b[i]);
            ones += b[i];
        end
        exp_bits.push_back((ones % 2) == 0);
    endtask

    task automatic plan_frame(input bit abort_f);
        int trailer = 0;
        logic [15:0] crc = 16'h6363;
        exp_bits.push_back(1'b1);
        foreach (fb[i]) begin
            push_byte(fb[i]);
            crc = crc_step(crc, fb[i]);
        end
`ifdef PICC_TX_CRC_A_EN
        if (!abort_f) begin
            push_byte(crc[7:0]);
            push_byte(crc[15:8]);
            trailer = 2;
        end
`endif
        exp_len.push_back(ETU * (1 + 9 * (fb.size() + trailer)));
        exp_und.push_back(abort_f);
    endtask

    task automatic wait_accept(output time at);
        bit got = 0;
        int t = 0;
        while (!got && t < 4000) begin
            @(negedge clk);
            got = s_ready;
            @(posedge clk);
            t++;
        end
        at = $time;
        #1;
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic drive(input bit abort_f, input int max_gap);
        time at;
        int  gap;
        acc_t.delete();
        for (int i = 0; i < fb.size(); i++) begin
            s_valid = 1'b1;
            s_data  = fb[i];
            s_last  = !abort_f && (i == fb.size() - 1);
            wait_accept(at);
            if (i == 0) first_acc_time = at;
            acc_t.push_back(at);
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (i != fb.size() - 1) begin
                gap = $urandom_range(max_gap, 0);
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run_frame(input bit abort_f, input int max_gap);
        plan_frame(abort_f);
        drive(abort_f, max_gap);
    endtask

    task automatic wait_idle();
        int t = 0;
        bit idle = 0;
        while (!idle && t < 30000) begin
            @(negedge clk);
            idle = !busy && !in_frame;
            t++;
        end
        if (!idle) check("idle_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor
    bit in_frame = 0;
    bit glitch = 0;
    bit cur_bit = 0;
    bit cur_und = 0;
    int cyc = 0;
    int cur_len = 0;
    bit gact = 0;
    int gcnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 0;
            gact = 0;
            exp_bits.delete();
            exp_len.delete();
            exp_und.delete();
        end else begin
            if (gact) begin
                if (busy && gcnt < 200) begin
                    gcnt++;
                end else begin
                    check("guard_len", gcnt, ETU);
                    gact = 0;
                end
            end
            if (tx_enable) begin
                if (!in_frame) begin
                    in_frame = 1;
                    cyc = 0;
                    glitch = 0;
                    if (exp_len.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                        cur_len = 0;
                        cur_und = 0;
                    end else begin
                        cur_len = exp_len.pop_front();
                        cur_und = exp_und.pop_front();
                    end
                    check("sof_latency", int'($time - first_acc_time), 5);
                end
                if (cyc % ETU == 0) begin
                    cur_bit = tx_data;
                    if (exp_bits.size() > 0) check("bit", tx_data, exp_bits.pop_front());
                    else check("extra_bit", 1, 0);
                end else if (tx_data !== cur_bit) begin
                    glitch = 1;
                end
                if (done || underrun) check("pulse_in_frame", 1, 0);
                cyc++;
            end else if (in_frame) begin
                in_frame = 0;
                check("frame_len", cyc, cur_len);
                check("bit_stable", glitch, 0);
                check("done", done, !cur_und);
                check("underrun", underrun, cur_und);
                check("busy_at_end", busy, 1);
                gact = 1;
                gcnt = 0;
            end else if (done || underrun) begin
                check("spurious_pulse", 1, 0);
            end
        end
    end

    initial begin
        int n;
        bit ab;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_enable", tx_enable, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_s_ready", s_ready, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ready_after_reset", s_ready, 1);

        fb = '{8'h26};
        run_frame(0, 0);
        fb = '{8'h00, 8'h00};
        run_frame(0, 10);
        fb = '{8'h12, 8'h34};
        run_frame(0, 10);

        fb = '{8'hA5, 8'h5A, 8'hC3};
        run_frame(0, 0);
        check("second_accept_in_data", int'((acc_t[1] - acc_t[0]) / 10), 33);

        fb = '{8'hFF};
        run_frame(1, 0);
        wait_idle();

        for (int f = 0; f < 8; f++) begin
            n  = $urandom_range(4, 1);
            ab = ($urandom_range(2, 0) == 0);
            fb.delete();
            for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(255, 0)));
            run_frame(ab, 80);
            if (ab) wait_idle();
        end
        wait_idle();

        fb = '{8'h3C};
        run_frame(1, 0);
        repeat (99) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_enable", tx_enable, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_s_ready", s_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fb = '{8'h12, 8'h34};
        run_frame(0, 5);
        wait_idle();

        check("bits_left", exp_bits.size(), 0);
        check("frames_left", exp_len.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/picc_tx_framer.md
# picc_tx_framer

Transmit framer for the PICC side of the ISO 14443-A 106 kbit/s link. It takes payload bytes over a valid/ready stream and emits a standard frame as a bit-serial ETU-timed stream: start-of-communication bit, then each byte LSB-first followed by its odd parity bit, with an optional CRC_A trailer. The output pair `tx_enable`/`tx_data` feeds the Manchester modulator's `in_enable`/`in_data` directly. `tx_enable` low means no modulation, which is end-of-communication.

## Interface
Parameters:
- `ETU_CLKS`, 32: `clk` cycles per bit (ETU) at fc/4.
- `CNT_W`, 6: ETU counter width; must satisfy 2^CNT_W ≥ ETU_CLKS.

Ports:
- `clk`  in  1  fc/4 clock (3.39 MHz); all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_valid`  in  1  payload byte valid.
- `s_data`  in  8  payload byte.
- `s_last`  in  1  marks final payload byte of frame.
- `s_ready`  out  1  byte accepted when `s_valid & s_ready`.
- `tx_enable`  out  1  frame active; to modulator `in_enable`.
- `tx_data`  out  1  current bit; to modulator `in_data`.
- `busy`  out  1  high from frame accept until guard time ends.
- `done`  out  1  one-cycle pulse at normal frame end.
- `underrun`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- Reset: all outputs 0, FSM in IDLE, holding register empty, CRC register 0x6363.
- One-byte holding register: `s_ready` = holding register empty and FSM not in GUARD. In IDLE, a handshake starts a frame.
- FSM states and transitions:
  - IDLE → SOF on first byte accept.
  - SOF → DATA after 1 ETU. `tx_data`=1.
  - DATA: 8 ETUs, shift register LSB-first → PARITY.
  - PARITY: 1 ETU, `tx_data` = ~^byte (odd parity).
  - PARITY → DATA if the holding register is full. The byte moves to the shift register and the holding register empties.
  - PARITY → next trailer byte if the last payload byte has been sent and CRC is enabled.
  - PARITY → EOF otherwise, after a byte marked `s_last`.
  - PARITY → ABORT if no byte is held and the last byte has not been sent.
  - EOF: `tx_enable`=0, `tx_data`=0, `done` pulse, → GUARD.
  - ABORT: `tx_enable`=0, `tx_data`=0, `underrun` pulse, holding register flushed, → GUARD.
  - GUARD: 1 ETU idle, `busy`=1, `s_ready`=0 → IDLE.
- The `s_last` flag is latched together with its byte. Bytes offered after `s_last` are not accepted until GUARD ends.
- Frame length (no CRC): 1 + 9·N ETUs of `tx_enable` high, for N payload bytes.

## Timing
- Accept edge in IDLE → next cycle `tx_enable`=1, `tx_data`=1 (SOF). Latency is 1 cycle.
- `tx_data` changes only on ETU boundaries, i.e. every `ETU_CLKS` cycles counted from the first cycle of SOF. `tx_enable` is steady for the whole frame.
- The ETU counter reloads to 0 on every state entry. The wrap at `ETU_CLKS`-1 is the bit boundary.
- `done` and `underrun` assert in the first cycle after `tx_enable` falls.
- Simultaneous byte accept and PARITY-end decision in the same cycle: the byte counts as held, so there is no underrun.
- `rst_n` asserted mid-frame: `tx_enable` drops immediately (asynchronous), CRC is reinitialised, and no `done` or `underrun` pulse is produced.

## Configuration
- `PICC_TX_CRC_A_EN` defined:
  - CRC_A (reflected polynomial 0x8408, init 0x6363, no final XOR) is updated over each payload byte as it enters the shift register.
  - After the last payload byte, two trailer bytes are sent, CRC low byte then high byte, each with odd parity.
  - Frame length becomes 1 + 9·(N+2) ETUs.
- Undefined: no CRC logic is built; the frame ends after the last payload parity bit.

## Structure
- Shared package `rfid_pkg`:
  - FSM state enum (IDLE, SOF, DATA, PARITY, CRC_LO, CRC_HI, EOF, ABORT, GUARD).
  - CRC_A constants: `CRC_A_INIT`=16'h6363, `CRC_A_POLY`=16'h8408.
  - Default `ETU_CLKS`.
- One sub-module: `crc_a_byte`, a combinational byte-wide CRC_A update (crc_in, data → crc_out). It is instantiated only under `PICC_TX_CRC_A_EN`.

## Test plan
- Single byte 0x26 with `s_last`, CRC off:
  - `tx_enable` high for exactly 10·32 = 320 cycles.
  - Bits are 1, 0,1,1,0,0,1,0,0, parity 0.
  - `done` pulses once; `busy` falls 32 cycles later.
- Two bytes 0x00, 0x00 with CRC on:
  - Trailer bytes 0xA0 then 0x1E.
  - Parities are 1,1,1,1.
  - Total 37·32 cycles enabled.
- Two bytes 0x12, 0x34 with CRC on: trailer 0x26, 0xCF.
- Underrun: send 0xFF without `s_last`, hold `s_valid` low → at end of the first parity bit, `tx_enable` falls and `underrun` pulses; no `done`.
- Back-to-back: 3 bytes presented with `s_valid` continuously high → no gaps, `s_ready` high once per byte, and the second byte is accepted during the first byte's DATA.
- Reset mid-DATA (cycle 100 of the frame) → `tx_enable`, `busy`, and `s_ready` are 0 while reset is asserted; a new frame after release starts with SOF and CRC 0x6363.
